// File: rtl/mem_bus_arbiter_pkg.sv
//------------------------------------------------------------------------------
// mem_bus_arbiter_pkg : shared states, port indices and helpers for the arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_bus_arbiter_pkg;

   localparam int unsigned WORD_SIZE_DEF = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Port indices double as the owner register encoding.
   localparam logic P_CPU = 1'b0;
   localparam logic P_DMA = 1'b1;

   function automatic logic [1:0] port_onehot(input logic owner);
      return owner ? 2'b10 : 2'b01;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
//------------------------------------------------------------------------------
// mem_bus_arbiter : two-port (CPU/DMA) memory arbiter with CPU priority,
//                   DMA starvation limit and programmable wait states
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned WORD_SIZE    = WORD_SIZE_DEF,
   parameter int unsigned WAIT_STATES  = 1,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [1:0]           req_i,
   input  logic [1:0]           we_i,
   input  logic [WORD_SIZE-1:0] addr0_i,
   input  logic [WORD_SIZE-1:0] addr1_i,
   input  logic [WORD_SIZE-1:0] wdata0_i,
   input  logic [WORD_SIZE-1:0] wdata1_i,
   output logic [1:0]           gnt_o,
   output logic [1:0]           ack_o,
   output logic [WORD_SIZE-1:0] rdata_o,
   output logic                 busy_o,
   output logic                 mem_en_o,
   output logic                 mem_write_o,
   output logic [WORD_SIZE-1:0] mem_addr_o,
   output logic [WORD_SIZE-1:0] mem_wdata_o,
   input  logic [WORD_SIZE-1:0] mem_rdata_i
);

   localparam int unsigned WAIT_W   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [WAIT_W-1:0]   WAIT_INIT  = WAIT_W'(WAIT_STATES);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   state_e                state_q,  state_d;
   logic                  owner_q,  owner_d;
   logic                  we_q,     we_d;
   logic [WORD_SIZE-1:0]  addr_q,   addr_d;
   logic [WORD_SIZE-1:0]  wdata_q,  wdata_d;
   logic [WORD_SIZE-1:0]  rdata_q,  rdata_d;
   logic [WAIT_W-1:0]     wait_q,   wait_d;
   logic [STARVE_W-1:0]   starve_q, starve_d;
   logic                  pick_dma;

   // DMA wins when it is alone, or when the CPU has starved it long enough.
   assign pick_dma = req_i[P_DMA] && (!req_i[P_CPU] || (starve_q == STARVE_MAX));

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      wait_d   = wait_q;
      starve_d = starve_q;

      case (state_q)
         S_IDLE: begin
            if (req_i != 2'b00) begin
               owner_d = pick_dma ? P_DMA : P_CPU;
               we_d    = pick_dma ? we_i[P_DMA] : we_i[P_CPU];
               addr_d  = pick_dma ? addr1_i : addr0_i;
               wdata_d = pick_dma ? wdata1_i : wdata0_i;
               wait_d  = WAIT_INIT;
               state_d = S_ACC;
               if (pick_dma || !req_i[P_DMA]) begin
                  starve_d = '0;
               end else if (starve_q != STARVE_MAX) begin
                  starve_d = starve_q + STARVE_W'(1);
               end
            end
         end
         S_ACC: begin
            if (wait_q == '0) begin
               if (!we_q) begin
                  rdata_d = mem_rdata_i;
               end
               state_d = S_DONE;
            end else begin
               wait_d = wait_q - WAIT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         owner_q  <= P_CPU;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         wait_q   <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         wait_q   <= wait_d;
         starve_q <= starve_d;
      end
   end

   // Outputs decode straight from registered state so reset clears them at once.
   assign busy_o      = (state_q != S_IDLE);
   assign mem_en_o    = (state_q == S_ACC);
   assign mem_write_o = mem_en_o && we_q;
   assign gnt_o       = ((state_q == S_ACC) || (state_q == S_DONE)) ? port_onehot(owner_q) : 2'b00;
   assign ack_o       = (state_q == S_DONE) ? port_onehot(owner_q) : 2'b00;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign rdata_o     = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_bus_arbiter : directed scoreboard bench for mem_bus_arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_bus_arbiter;

   typedef struct packed {
      logic [1:0]  port;
      logic [15:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   int          checks   = 0;
   int          failures = 0;
   exp_t        exp_a[$];
   exp_t        exp_b[$];
   int          en_cnt_a = 0;
   int          wr_cnt_a = 0;

   // DUT A: one wait state
   logic [1:0]  req_a, we_a, gnt_a, ack_a;
   logic [15:0] addr0_a, addr1_a, wdata0_a, wdata1_a, rdata_a;
   logic        busy_a, mem_en_a, mem_write_a;
   logic [15:0] mem_addr_a, mem_wdata_a, mem_rdata_a;

   // DUT B: zero wait states
   logic [1:0]  req_b, we_b, gnt_b, ack_b;
   logic [15:0] addr0_b, addr1_b, wdata0_b, wdata1_b, rdata_b;
   logic        busy_b, mem_en_b, mem_write_b;
   logic [15:0] mem_addr_b, mem_wdata_b, mem_rdata_b;

   always #5 clk = ~clk;

   // Memory model: one fixed word, everything else is the address scrambled.
   assign mem_rdata_a = (mem_addr_a == 16'h0010) ? 16'hBEEF : (mem_addr_a ^ 16'h5A5A);
   assign mem_rdata_b = (mem_addr_b == 16'h0010) ? 16'hBEEF : (mem_addr_b ^ 16'h5A5A);

   mem_bus_arbiter #(.WORD_SIZE(16), .WAIT_STATES(1), .STARVE_LIMIT(3)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .we_i(we_a),
      .addr0_i(addr0_a), .addr1_i(addr1_a), .wdata0_i(wdata0_a), .wdata1_i(wdata1_a),
      .gnt_o(gnt_a), .ack_o(ack_a), .rdata_o(rdata_a), .busy_o(busy_a),
      .mem_en_o(mem_en_a), .mem_write_o(mem_write_a), .mem_addr_o(mem_addr_a),
      .mem_wdata_o(mem_wdata_a), .mem_rdata_i(mem_rdata_a)
   );

   mem_bus_arbiter #(.WORD_SIZE(16), .WAIT_STATES(0), .STARVE_LIMIT(3)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .we_i(we_b),
      .addr0_i(addr0_b), .addr1_i(addr1_b), .wdata0_i(wdata0_b), .wdata1_i(wdata1_b),
      .gnt_o(gnt_b), .ack_o(ack_b), .rdata_o(rdata_b), .busy_o(busy_b),
      .mem_en_o(mem_en_b), .mem_write_o(mem_write_b), .mem_addr_o(mem_addr_b),
      .mem_wdata_o(mem_wdata_b), .mem_rdata_i(mem_rdata_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack_a(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (ack_a != 2'b00) begin
            cyc = i;
            break;
         end
      end
      if (cyc < 0) chk("a_ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_ack_b(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (ack_b != 2'b00) begin
            cyc = i;
            break;
         end
      end
      if (cyc < 0) chk("b_ack_timeout", 32'd0, 32'd1);
   endtask

   // Scoreboards and bus invariants, sampled mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      chk("a_gnt_both", {31'd0, gnt_a == 2'b11}, 32'd0);
      chk("a_write_wo_en", {31'd0, mem_write_a && !mem_en_a}, 32'd0);
      chk("b_gnt_both", {31'd0, gnt_b == 2'b11}, 32'd0);
      if (mem_en_a) en_cnt_a++;
      if (mem_write_a) wr_cnt_a++;
      if (ack_a != 2'b00) begin
         if (exp_a.size() == 0) begin
            chk("a_ack_unexpected", {30'd0, ack_a}, 32'd0);
         end else begin
            e = exp_a.pop_front();
            chk("a_ack_port", {30'd0, ack_a}, {30'd0, e.port});
            chk("a_rdata", {16'd0, rdata_a}, {16'd0, e.rdata});
         end
      end
      if (ack_b != 2'b00) begin
         if (exp_b.size() == 0) begin
            chk("b_ack_unexpected", {30'd0, ack_b}, 32'd0);
         end else begin
            e = exp_b.pop_front();
            chk("b_ack_port", {30'd0, ack_b}, {30'd0, e.port});
            chk("b_rdata", {16'd0, rdata_b}, {16'd0, e.rdata});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int base;
      rst_n = 1'b0;
      req_a = '0; we_a = '0; addr0_a = '0; addr1_a = '0; wdata0_a = '0; wdata1_a = '0;
      req_b = '0; we_b = '0; addr0_b = '0; addr1_b = '0; wdata0_b = '0; wdata1_b = '0;
      repeat (3) tick();
      chk("rst_gnt", {30'd0, gnt_a}, 32'd0);
      chk("rst_ack", {30'd0, ack_a}, 32'd0);
      chk("rst_busy", {31'd0, busy_a}, 32'd0);
      chk("rst_mem_en", {31'd0, mem_en_a}, 32'd0);
      chk("rst_mem_addr", {16'd0, mem_addr_a}, 32'd0);
      chk("rst_rdata", {16'd0, rdata_a}, 32'd0);
      chk("rst_b_busy", {31'd0, busy_b}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // CPU read with one wait state
      req_a = 2'b01; we_a = 2'b00; addr0_a = 16'h0010;
      exp_a.push_back('{port: 2'b01, rdata: 16'hBEEF});
      base = en_cnt_a;
      tick();
      chk("rd_gnt", {30'd0, gnt_a}, 32'h1);
      chk("rd_en1", {31'd0, mem_en_a}, 32'd1);
      chk("rd_addr", {16'd0, mem_addr_a}, 32'h0010);
      chk("rd_nowrite", {31'd0, mem_write_a}, 32'd0);
      req_a = 2'b00;
      tick();
      chk("rd_en2", {31'd0, mem_en_a}, 32'd1);
      chk("rd_noack", {30'd0, ack_a}, 32'd0);
      tick();
      chk("rd_ack", {30'd0, ack_a}, 32'h1);
      chk("rd_en_off", {31'd0, mem_en_a}, 32'd0);
      tick();
      chk("rd_idle", {31'd0, busy_a}, 32'd0);
      chk("rd_en_cycles", en_cnt_a - base, 32'd2);

      // DMA write; rdata must be untouched
      req_a = 2'b10; we_a = 2'b10; addr1_a = 16'h00A0; wdata1_a = 16'h1234;
      exp_a.push_back('{port: 2'b10, rdata: 16'hBEEF});
      base = wr_cnt_a;
      tick();
      chk("wr_gnt", {30'd0, gnt_a}, 32'h2);
      chk("wr_strobe", {31'd0, mem_write_a}, 32'd1);
      chk("wr_addr", {16'd0, mem_addr_a}, 32'h00A0);
      chk("wr_data", {16'd0, mem_wdata_a}, 32'h1234);
      req_a = 2'b00;
      tick();
      chk("wr_strobe2", {31'd0, mem_write_a}, 32'd1);
      tick();
      chk("wr_ack", {30'd0, ack_a}, 32'h2);
      chk("wr_strobe_off", {31'd0, mem_write_a}, 32'd0);
      tick();
      chk("wr_cycles", wr_cnt_a - base, 32'd2);

      // Both requesting continuously: starvation forces every fourth grant to DMA
      req_a = 2'b11; we_a = 2'b00; addr0_a = 16'h0020; addr1_a = 16'h0030;
      for (int k = 0; k < 8; k++) begin
         if (k % 4 == 3) exp_a.push_back('{port: 2'b10, rdata: 16'h5A6A});
         else            exp_a.push_back('{port: 2'b01, rdata: 16'h5A7A});
      end
      for (int k = 0; k < 8; k++) begin
         wait_ack_a(n);
         chk("starve_latency", n, (k == 0) ? 32'd3 : 32'd4);
      end
      req_a = 2'b00;
      tick();
      chk("starve_idle", {31'd0, busy_a}, 32'd0);

      // Zero wait states: ack two cycles after request, then every three
      req_b = 2'b01; we_b = 2'b00; addr0_b = 16'h0040;
      repeat (3) exp_b.push_back('{port: 2'b01, rdata: 16'h5A1A});
      wait_ack_b(n);
      chk("w0_first", n, 32'd2);
      wait_ack_b(n);
      chk("w0_b2b_1", n, 32'd3);
      wait_ack_b(n);
      chk("w0_b2b_2", n, 32'd3);
      req_b = 2'b00;
      tick();
      chk("w0_idle", {31'd0, busy_b}, 32'd0);

      // Reset in the middle of a write
      req_a = 2'b01; we_a = 2'b01; addr0_a = 16'h0050; wdata0_a = 16'hCAFE;
      tick();
      chk("rw_strobe", {31'd0, mem_write_a}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rw_en_drop", {31'd0, mem_en_a}, 32'd0);
      chk("rw_wr_drop", {31'd0, mem_write_a}, 32'd0);
      chk("rw_busy", {31'd0, busy_a}, 32'd0);
      chk("rw_gnt", {30'd0, gnt_a}, 32'd0);
      chk("rw_rdata", {16'd0, rdata_a}, 32'd0);
      repeat (2) tick();
      @(negedge clk) rst_n = 1'b1;
      exp_a.push_back('{port: 2'b01, rdata: 16'h0000});
      wait_ack_a(n);
      chk("rw_rearb", n, 32'd3);
      req_a = 2'b00;
      tick();

      // Request dropped during access still completes exactly once
      we_a = 2'b00; addr0_a = 16'h0060; req_a = 2'b01;
      exp_a.push_back('{port: 2'b01, rdata: 16'h5A3A});
      tick();
      chk("drop_gnt", {30'd0, gnt_a}, 32'h1);
      req_a = 2'b00;
      wait_ack_a(n);
      chk("drop_latency", n, 32'd2);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("drop_quiet", {29'd0, busy_a, gnt_a}, 32'd0);
      end

      chk("a_queue_empty", exp_a.size(), 32'd0);
      chk("b_queue_empty", exp_b.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
